order_uart_tx: RTL

Order-frame transmitter for the HFT trading path. It accepts one order (address, buy/sell code, timestamp) from the TX address mux with a valid/busy handshake. It serializes the order into a fixed byte frame and drives the physical UART `tx` line. It is the transmit-side counterpart of the market-data receive path, which decodes price/volume frames from `rx`.

---
 rtl/hft_pkg.sv | 32 +++
 rtl/uart_byte_tx.sv | 78 +++++++
 rtl/order_uart_tx.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/hft_pkg.sv
// Shared types and constants for the HFT order transmit path.
// ORDER_TX_CHECKSUM_EN selects the 8-byte frame with trailing XOR checksum.
package hft_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam int unsigned FRAME_LEN_BASE = 7;
  localparam int unsigned FRAME_LEN_CSUM = 8;
`ifdef ORDER_TX_CHECKSUM_EN
  localparam int unsigned FRAME_LEN = FRAME_LEN_CSUM;
`else
  localparam int unsigned FRAME_LEN = FRAME_LEN_BASE;
`endif

  // Wide enough to hold FRAME_LEN itself (one past the last byte index).
  localparam int unsigned IDX_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT,
    ST_DONE
  } framer_state_e;

  typedef struct packed {
    logic [7:0]  addr;
    logic [7:0]  buysell;
    logic [31:0] timestamp;
  } order_t;

endpackage

// File: rtl/uart_byte_tx.sv
// UART byte serializer: start bit, 8 data bits LSB first, stop bit.
// Holds one pending byte so the next start bit follows the stop bit with no gap.
module uart_byte_tx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_dv,
  output logic       tx,
  output logic       byte_done,
  output logic       active
);

  localparam int unsigned     CNT_W     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BAUD_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [3:0]       STOP_IDX  = 4'd9;

  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bit_idx;
  logic [8:0]       shifter;
  logic             pend_valid;
  logic [7:0]       pend_byte;

  logic       bit_end_c;
  logic       stop_end_c;
  logic       load_c;
  logic [7:0] load_byte_c;

  always_comb begin
    bit_end_c   = active && (baud_cnt == BAUD_LAST);
    stop_end_c  = bit_end_c && (bit_idx == STOP_IDX);
    load_c      = (!active && byte_dv) || (stop_end_c && pend_valid);
    load_byte_c = active ? pend_byte : byte_in;
  end

  // byte_done is registered one cycle early so it is high in the last stop-bit cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx         <= 1'b1;
      byte_done  <= 1'b0;
      active     <= 1'b0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shifter    <= '0;
      pend_valid <= 1'b0;
      pend_byte  <= '0;
    end else begin
      byte_done <= active && (bit_idx == STOP_IDX) && (baud_cnt == BAUD_PRE);
      if (active && byte_dv) begin
        pend_valid <= 1'b1;
        pend_byte  <= byte_in;
      end
      if (load_c) begin
        active   <= 1'b1;
        tx       <= 1'b0;
        shifter  <= {1'b1, load_byte_c};
        bit_idx  <= '0;
        baud_cnt <= '0;
        if (active) pend_valid <= 1'b0;
      end else if (stop_end_c) begin
        active   <= 1'b0;
        tx       <= 1'b1;
        bit_idx  <= '0;
        baud_cnt <= '0;
      end else if (bit_end_c) begin
        tx       <= shifter[0];
        shifter  <= {1'b0, shifter[8:1]};
        bit_idx  <= bit_idx + 4'd1;
        baud_cnt <= '0;
      end else if (active) begin
        baud_cnt <= baud_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/order_uart_tx.sv
// Order framer: captures one order and sends SYNC, addr, buysell, timestamp[31:0]
// over UART; ORDER_TX_CHECKSUM_EN appends the XOR checksum of bytes 1..6.
module order_uart_tx
  import hft_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  tx_addr,
  input  logic [7:0]  tx_buysell,
  input  logic [31:0] tx_timestamp,
  input  logic        tx_dv,
  output logic        tx_busy,
  output logic        tx,
  output logic        frame_done,
  output logic [7:0]  drop_cnt
);

  localparam logic [IDX_W-1:0] FRAME_END = IDX_W'(FRAME_LEN);

  framer_state_e    state, state_nxt;
  order_t           frame;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             tail, tail_nxt;
  logic             accept_c;
  logic             byte_dv_c;
  logic [7:0]       byte_c;
  logic             byte_done;
  logic             ser_active;
`ifdef ORDER_TX_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  // idx is the next byte to hand over; tail marks that only the final byte is left on the wire.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    tail_nxt  = tail;
    accept_c  = 1'b0;
    byte_dv_c = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        state_nxt = ST_IDLE;
        if (tx_dv) begin
          accept_c  = 1'b1;
          state_nxt = ST_LOAD;
          idx_nxt   = '0;
          tail_nxt  = 1'b0;
        end
      end
      // SYNC is constant, so it launches while the checksum is folded.
      ST_LOAD: begin
        byte_dv_c = 1'b1;
        idx_nxt   = IDX_W'(1);
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        byte_dv_c = 1'b1;
        idx_nxt   = idx + IDX_W'(1);
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (byte_done) begin
          if (idx != FRAME_END) state_nxt = ST_SEND;
          else if (tail)        state_nxt = ST_DONE;
          else                  tail_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_c = SYNC_BYTE;
    case (idx)
      IDX_W'(1): byte_c = frame.addr;
      IDX_W'(2): byte_c = frame.buysell;
      IDX_W'(3): byte_c = frame.timestamp[31:24];
      IDX_W'(4): byte_c = frame.timestamp[23:16];
      IDX_W'(5): byte_c = frame.timestamp[15:8];
      IDX_W'(6): byte_c = frame.timestamp[7:0];
`ifdef ORDER_TX_CHECKSUM_EN
      IDX_W'(7): byte_c = csum;
`endif
      default:   byte_c = SYNC_BYTE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      tail       <= 1'b0;
      tx_busy    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      tail       <= tail_nxt;
      tx_busy    <= (state_nxt == ST_LOAD) || (state_nxt == ST_SEND) || (state_nxt == ST_WAIT);
      frame_done <= (state_nxt == ST_DONE);
    end
  end

  // Inputs are latched only on the accepting edge; later bus activity is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame    <= '0;
      drop_cnt <= '0;
`ifdef ORDER_TX_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      if (accept_c) begin
        frame.addr      <= tx_addr;
        frame.buysell   <= tx_buysell;
        frame.timestamp <= tx_timestamp;
      end
      if (tx_dv && tx_busy && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
`ifdef ORDER_TX_CHECKSUM_EN
      if (state == ST_LOAD) begin
        csum <= frame.addr ^ frame.buysell ^ frame.timestamp[31:24] ^
                frame.timestamp[23:16] ^ frame.timestamp[15:8] ^ frame.timestamp[7:0];
      end
`endif
    end
  end

  // An idle framer must never find the serializer still shifting.
  always_ff @(posedge clk) begin
    if (!reset && (state == ST_IDLE)) assert (!ser_active);
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_byte_tx (
    .clk      (clk),
    .reset    (reset),
    .byte_in  (byte_c),
    .byte_dv  (byte_dv_c),
    .tx       (tx),
    .byte_done(byte_done),
    .active   (ser_active)
  );

endmodule
